// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate format codes and occupancy states for the immediate generator.
// The optional Zicsr format (IMM_Z) is produced only when IMM_GEN_ZICSR_EN is defined.
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_NONE = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/imm_gen_extract.sv
// Combinational RV32 immediate decode: opcode selects format, result sign/zero-extended to XLEN.
// Define IMM_GEN_ZICSR_EN to decode CSR-immediate (uimm) forms of the SYSTEM opcode.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      typ
);

    always_comb begin
        imm = '0;
        typ = IMM_NONE;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm = XLEN'($signed(instr[31:20]));
                typ = IMM_I;
            end
            OP_STORE: begin
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                typ = IMM_S;
            end
            OP_BRANCH: begin
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                typ = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                // Upper 20 bits in place; bit 31 still sign-extends on 64-bit builds
                imm = XLEN'($signed({instr[31:12], 12'b0}));
                typ = IMM_U;
            end
            OP_JAL: begin
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                typ = IMM_J;
            end
`ifdef IMM_GEN_ZICSR_EN
            OP_SYSTEM: begin
                if (instr[14]) begin
                    imm = XLEN'(instr[19:15]);
                    typ = IMM_Z;
                end
            end
`else
`endif
            default: begin
                imm = '0;
                typ = IMM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipeline stage: decodes the immediate of each accepted instruction into a small in-order buffer.
// in_ready depends only on the registered occupancy, never on out_ready. Optional macro: IMM_GEN_ZICSR_EN.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [31:0]     out_instr
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [31:0]     instr;
    } entry_t;

    entry_t          mem [BUF_DEPTH];
    logic [CW-1:0]   count;
    logic [CW-1:0]   wr_idx;
    occ_state_e      state;
    logic [XLEN-1:0] ext_imm;
    logic [2:0]      ext_type;
    logic            do_in;
    logic            do_out;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr (in_instr),
        .imm   (ext_imm),
        .typ   (ext_type)
    );

    always_comb begin
        state = OCC_PART;
        if (count == '0)
            state = OCC_EMPTY;
        else if (count == CW'(BUF_DEPTH))
            state = OCC_FULL;
    end

    assign in_ready  = !rst && (state != OCC_FULL);
    assign out_valid = (state != OCC_EMPTY);
    assign do_in     = in_valid && in_ready;
    assign do_out    = out_valid && out_ready;
    // Entry 0 is always the oldest; a simultaneous pop shifts the write slot down by one
    assign wr_idx    = do_out ? count - 1'b1 : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                mem[i] <= entry_t'{imm: '0, typ: IMM_NONE, instr: '0};
        end else begin
            if (do_out)
                for (int i = 0; i < BUF_DEPTH - 1; i++)
                    mem[i] <= mem[i + 1];
            if (do_in)
                for (int i = 0; i < BUF_DEPTH; i++)
                    if (wr_idx == CW'(i))
                        mem[i] <= entry_t'{imm: ext_imm, typ: ext_type, instr: in_instr};
            case ({do_in, do_out})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_imm   = mem[0].imm;
    assign out_type  = mem[0].typ;
    assign out_instr = mem[0].instr;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (XLEN=32, BUF_DEPTH=2).
// Zicsr expectations follow IMM_GEN_ZICSR_EN when it is defined for the build.
module tb_imm_gen_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic [31:0]     out_instr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] exp_q[$];

    imm_gen_stage #(.XLEN(XLEN), .BUF_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_type  (out_type),
        .out_instr (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
    endtask

    // Push one instruction with out_ready=0, then check the head is the expected value
    task automatic single(input string tag, input logic [31:0] ins,
                          input logic [31:0] e_imm, input logic [2:0] e_type);
        drive(1'b1, ins, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_imm"}, out_imm, e_imm);
        check({tag, "_type"}, out_type, e_type);
        step();
    endtask

    logic [31:0] stream_in  [4] = '{32'h12345037, 32'h0040006F, 32'hFE000EE3, 32'h00002423};
    logic [31:0] stream_imm [4] = '{32'h12345000, 32'h00000004, 32'hFFFFFFFC, 32'h00000008};
    logic [2:0]  stream_typ [4] = '{3'd3, 3'd4, 3'd2, 3'd1};

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_imm", out_imm, 32'h0);
        check("post_rst_type", out_type, 3'd7);
        check("post_rst_instr", out_instr, 32'h0);

        // Single I-type, ready downstream: visible one cycle after accept
        drive(1'b1, 32'hFFF00093, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        check("addi_valid", out_valid, 1'b1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_type", out_type, 3'd0);
        check("addi_instr", out_instr, 32'hFFF00093);
        step();
        check("addi_drain", out_valid, 1'b0);

        // Back-to-back stream at full rate
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, stream_in[k], 1'b1);
            exp_q.push_back(stream_imm[k]);
            check($sformatf("stream_ready%0d", k), in_ready, 1'b1);
            step();
            check($sformatf("stream_valid%0d", k), out_valid, 1'b1);
            check($sformatf("stream_imm%0d", k), out_imm, exp_q.pop_front());
            check($sformatf("stream_type%0d", k), out_type, stream_typ[k]);
            check($sformatf("stream_instr%0d", k), out_instr, stream_in[k]);
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("stream_empty", out_valid, 1'b0);

        // Backpressure: third push while full must be dropped
        drive(1'b1, 32'h00500013, 1'b0);
        step();
        check("bp_ready1", in_ready, 1'b1);
        drive(1'b1, 32'h80000037, 1'b0);
        step();
        check("bp_ready2", in_ready, 1'b0);
        check("bp_head_imm", out_imm, 32'h00000005);
        drive(1'b1, 32'h0FF00013, 1'b0);
        step();
        step();
        check("bp_hold_imm", out_imm, 32'h00000005);
        check("bp_hold_instr", out_instr, 32'h00500013);
        check("bp_hold_ready", in_ready, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        check("bp_first_imm", out_imm, 32'h00000005);
        step();
        check("bp_second_valid", out_valid, 1'b1);
        check("bp_second_imm", out_imm, 32'h80000000);
        check("bp_second_type", out_type, 3'd3);
        step();
        check("bp_no_third", out_valid, 1'b0);

        // Assorted formats and the unknown-opcode fallback
        single("lw_neg", 32'h80002003, 32'hFFFFF800, 3'd0);
        single("rtype", 32'h00000033, 32'h0, 3'd7);
        single("jal_neg", 32'hFFDFF0EF, 32'hFFFFFFFC, 3'd4);
`ifdef IMM_GEN_ZICSR_EN
        single("csrrwi", 32'h0002D073, 32'h5, 3'd5);
`else
        single("csrrwi", 32'h0002D073, 32'h0, 3'd7);
`endif

        // Reset while full discards everything
        drive(1'b1, 32'h00100013, 1'b0);
        step();
        drive(1'b1, 32'h00200013, 1'b0);
        step();
        check("mid_full_ready", in_ready, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", in_ready, 1'b1);
        check("mid_rel_type", out_type, 3'd7);
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mid_no_stale%0d", k), out_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
